jk_mod_counter: RTL
===================

// Module: jk_mod_counter
// PURPOSE
//  Synchronous up/down mod-N counter built from per-bit JK stages. It is the
//  consumer/driver stage around the JK flip-flop: excitation logic derives each
//  bit's J,K from current q and the requested next state, then clocks the JK cells.
//  Used as the lab's reference sequential counter (decade counter by default).
// PARAMETERS
//  WIDTH    4   counter width in bits; must satisfy 2**WIDTH >= MODULUS
//  MODULUS  10  count range 0..MODULUS-1; must be 2..2**WIDTH
// PORTS
//  clk    in   1      clock; all state updates on posedge clk
//  rst_n  in   1      synchronous reset, active-low
//  en     in   1      count enable
//  up     in   1      direction: 1 = increment, 0 = decrement
//  load   in   1      synchronous parallel load
//  din    in   WIDTH  load value
//  q      out  WIDTH  count value (registered)
//  qb     out  WIDTH  bitwise complement of q (registered, always == ~q)
//  tc     out  1      terminal count (combinational)
// BEHAVIOUR
//  - One clock, clk. Reset is synchronous, active-low, on rst_n.
//  - Reset: rst_n==0 sampled at posedge -> q=0, qb={WIDTH{1}} next cycle. No async path.
//  - Priority per posedge: rst_n low > load > en > hold.
//  - load=1: q <= din if din < MODULUS, else q <= 0 (out-of-range load clears).
//    en and up are ignored in that cycle.
//  - en=1, load=0, up=1: q <= (q==MODULUS-1) ? 0 : q+1.
//  - en=1, load=0, up=0: q <= (q==0) ? MODULUS-1 : q-1.
//  - en=0, load=0: hold (every JK stage gets J=K=0).
//  - Latency: 1 clock from sampled control to updated q/qb. No internal pipeline.
//  - Excitation: per bit i with target n_i: J_i = n_i & ~q_i, K_i = ~n_i & q_i.
//    Toggle (J=K=1) is never generated. Each bit is one jk_stage.
//  - qb updates in the same edge as q. qb never lags q by a cycle.
//  - tc = rst_n & en & ~load & (up ? q==MODULUS-1 : q==0).
//    tc flags the wrap edge that the next posedge will take.
//  - Reset mid-count: the next posedge forces 0 regardless of en/load/up.
//  - Illegal state: q >= MODULUS (possible only with 2**WIDTH > MODULUS).
//    Up-count -> 0. Down-count -> MODULUS-1. Self-correcting in one enabled edge.
//  - Direction change takes effect on the very next enabled edge. No extra hold state.
// STRUCTURE
//  - Shared package jk_pkg: localparam JK_HOLD=2'b00, JK_RESET=2'b01,
//    JK_SET=2'b10, JK_TOGGLE=2'b11 (jk bus encoding {J,K}).
//  - Sub-module jk_stage: one JK bit.
//    Ports: clk, rst_n, jk[1:0], q, qb.
//    Behaviour: sync active-low reset to q=0/qb=1, then hold/reset/set/toggle
//    per jk_pkg encoding.
//  - Top: next-state mux (reset/load/up/down/hold) -> excitation -> WIDTH x jk_stage
//    (generate loop) -> tc decode.
// TESTING  (WIDTH=4, MODULUS=10; check q and qb==~q after every posedge)
//  1 rst_n=0 for 2 edges with en=1,up=1 -> q=0, qb=4'hF, tc=0 during reset.
//  2 rst_n=1,en=1,up=1, 12 edges -> q=1..9,0,1,2.
//    tc=1 exactly while q==9. Wrap 9->0 occurs on the edge after tc.
//  3 up=0 from q=2, 4 edges -> q=1,0,9,8. tc=1 while q==0.
//  4 load=1,din=7 with en=1,up=0 -> q=7.
//    Then load=1,din=12 -> q=0 (clamp). Then load=0,en=0, 3 edges -> q holds 0.
//  5 Count to q=5, then assert rst_n=0 for 1 edge with en=1 -> q=0.
//    Release rst_n -> next edge q=1.
//  6 Force illegal q=13 via jk_stage hierarchy.
//    up=1 edge -> q=0. Repeat with up=0 -> q=9. tc=0 while q==13.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared JK encoding for the counter slice: the {J,K} bus values and the
// excitation helper that turns (target, current) into a {J,K} pair.
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // J rises only when the bit must go 0->1, K only when it must go 1->0,
    // so JK_TOGGLE can never come out of this.
    function automatic logic [1:0] jk_excite(input logic n_bit, input logic q_bit);
        return {n_bit & ~q_bit, ~n_bit & q_bit};
    endfunction

endpackage

// File: rtl/jk_stage.sv
// One JK flip-flop bit with separately registered true and complement outputs.
// Synchronous active-low reset drives q=0 / qb=1.
module jk_stage
    import jk_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] jk,
    output logic       q,
    output logic       qb
);

    logic r_q;
    logic r_qb;

    // qb is its own register so it switches on the same edge as q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q  <= 1'b0;
            r_qb <= 1'b1;
        end else begin
            case (jk)
                JK_RESET: begin
                    r_q  <= 1'b0;
                    r_qb <= 1'b1;
                end
                JK_SET: begin
                    r_q  <= 1'b1;
                    r_qb <= 1'b0;
                end
                JK_TOGGLE: begin
                    r_q  <= ~r_q;
                    r_qb <= ~r_qb;
                end
                default: begin
                    r_q  <= r_q;
                    r_qb <= r_qb;
                end
            endcase
        end
    end

    assign q  = r_q;
    assign qb = r_qb;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down mod-N counter: next-state mux -> JK excitation -> one jk_stage per bit,
// with a combinational terminal-count flag for the upcoming wrap edge.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc
);

    // Compare in WIDTH+1 bits so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qb;
    logic [WIDTH-1:0] w_next;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_illegal;

    assign w_at_max  = (w_q == MAX_VAL);
    assign w_at_zero = (w_q == '0);
    assign w_illegal = ({1'b0, w_q} >= MOD_EXT);

    // Out-of-range states fold back to 0 going up and to MAX_VAL going down.
    always_comb begin
        w_next = w_q;
        if (!rst_n) begin
            w_next = '0;
        end else if (load) begin
            w_next = ({1'b0, din} < MOD_EXT) ? din : '0;
        end else if (en) begin
            if (up) begin
                w_next = (w_at_max || w_illegal) ? '0 : w_q + 1'b1;
            end else begin
                w_next = (w_at_zero || w_illegal) ? MAX_VAL : w_q - 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            jk_stage u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .jk    (jk_excite(w_next[gi], w_q[gi])),
                .q     (w_q[gi]),
                .qb    (w_qb[gi])
            );
        end
    endgenerate

    assign q  = w_q;
    assign qb = w_qb;
    assign tc = rst_n & en & ~load & (up ? w_at_max : w_at_zero);

endmodule
